// File: rtl/rtc_alarm_pkg.sv
// rtl/rtc_alarm_pkg.sv - register map, bit positions, scan states and helpers for rtc_alarm_sched
package rtc_alarm_pkg;

  localparam int OFF_CTRL  = 0;
  localparam int OFF_PRESC = 1;
  localparam int OFF_CNT   = 2;
  localparam int OFF_STAT  = 3;
  localparam int OFF_CMP0  = 4;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;
  localparam int STAT_OVR_BIT = 15;
  localparam int CHCTL_EN_BIT = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rtc_rr_arbiter.sv
// rtl/rtc_rr_arbiter.sv - round-robin presenter of pending alarms as intr plus channel vector
module rtc_rr_arbiter
  import rtc_alarm_pkg::*;
#(
  parameter int CHANNELS = 4,
  localparam int VW = clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pending,
  input  logic                ack,
  output logic [VW-1:0]       vec,
  output logic                intr,
  output logic [VW-1:0]       ptr
);

  logic [VW-1:0] ptr_next;
  logic [VW-1:0] pick;
  logic          found;
  int            j;

  always_comb begin
    ptr_next = ptr;
    if (ack && intr) ptr_next = (int'(vec) == CHANNELS - 1) ? '0 : vec + 1'b1;
  end

  // pending is the next-state vector, so a set colliding with an ack keeps intr up
  always_comb begin
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      j = (int'(ptr_next) + i) % CHANNELS;
      if (!found && pending[j]) begin
        found = 1'b1;
        pick  = VW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr  <= '0;
      vec  <= '0;
      intr <= 1'b0;
    end else begin
      ptr  <= ptr_next;
      vec  <= pick;
      intr <= |pending;
    end
  end

endmodule

// File: rtl/rtc_alarm_sched.sv
// rtl/rtc_alarm_sched.sv - prescaled RTC with CHANNELS compare slots, scan FSM and IO register bus
// Optional periodic reload per channel: define RTC_ALARM_PERIODIC_EN.
module rtc_alarm_sched
  import rtc_alarm_pkg::*;
#(
  parameter int          CHANNELS   = 4,
  parameter int          CNT_SIZE   = 16,
  parameter int          PRESC_SIZE = 10,
  parameter logic [5:0]  BASE_ADDR  = 6'h00,
  localparam int         VW         = clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          addr,
  input  logic                wr,
  input  logic                rd,
  input  logic [CNT_SIZE-1:0] bus_in,
  output logic [CNT_SIZE-1:0] bus_out,
  output logic                intr,
  output logic [VW-1:0]       vec,
  input  logic                int_rst
);

  localparam int NREG_BASE = OFF_CMP0 + 2 * CHANNELS;
`ifdef RTC_ALARM_PERIODIC_EN
  localparam int NREG = NREG_BASE + CHANNELS;
`else
  localparam int NREG = NREG_BASE;
`endif

  logic [6:0]            off;
  logic [5:0]            off6;
  logic                  hit, wr_hit, clr, tick;
  logic                  en, ovr, ovr_set, rescan, rescan_n, scan_hit;
  logic [PRESC_SIZE-1:0] presc_reg, presc_cnt;
  logic [CNT_SIZE-1:0]   cnt;
  logic [CNT_SIZE-1:0]   cmp [CHANNELS];
  logic                  ch_en [CHANNELS];
  logic [CHANNELS-1:0]   pending, pend_next, set_mask, ack_mask, stat_clr;
  logic [VW-1:0]         idx, idx_n, rr_ptr;
  scan_state_t           state, state_n;

  // bit 6 of the 7-bit difference flags addresses below BASE_ADDR
  assign off    = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign off6   = off[5:0];
  assign hit    = !off[6] && (int'(off6) < NREG);
  assign wr_hit = wr && hit;
  assign clr    = wr_hit && (off6 == 6'(OFF_CTRL)) && bus_in[CTRL_CLR_BIT];
  assign tick   = en && !clr && (presc_cnt >= presc_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en        <= 1'b0;
      presc_reg <= '0;
      presc_cnt <= '0;
      cnt       <= '0;
      ovr       <= 1'b0;
      pending   <= '0;
      state     <= ST_IDLE;
      idx       <= '0;
      rescan    <= 1'b0;
    end else begin
      if (wr_hit && off6 == 6'(OFF_CTRL))  en <= bus_in[CTRL_EN_BIT];
      if (wr_hit && off6 == 6'(OFF_PRESC)) presc_reg <= bus_in[PRESC_SIZE-1:0];
      if (clr || tick)  presc_cnt <= '0;
      else if (en)      presc_cnt <= presc_cnt + 1'b1;
      if (clr)                                   cnt <= '0;
      else if (wr_hit && off6 == 6'(OFF_CNT))    cnt <= bus_in;
      else if (tick)                             cnt <= cnt + 1'b1;
      if (ovr_set) ovr <= 1'b1;
      else if (wr_hit && off6 == 6'(OFF_STAT) && bus_in[STAT_OVR_BIT]) ovr <= 1'b0;
      pending <= pend_next;
      state   <= state_n;
      idx     <= idx_n;
      rescan  <= rescan_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    rescan_n = rescan;
    ovr_set  = 1'b0;
    case (state)
      ST_IDLE: if (tick) begin
        state_n = ST_SCAN;
        idx_n   = '0;
      end
      ST_SCAN: if (int'(idx) == CHANNELS - 1) begin
        if (tick || rescan) begin
          idx_n    = '0;
          rescan_n = 1'b0;
          ovr_set  = tick && rescan;
        end else begin
          state_n = ST_IDLE;
        end
      end else begin
        idx_n = idx + 1'b1;
        if (tick) begin
          if (rescan) ovr_set  = 1'b1;
          else        rescan_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign scan_hit  = (state == ST_SCAN) && ch_en[idx] && (cmp[idx] == cnt);
  assign set_mask  = scan_hit ? (CHANNELS'(1) << idx) : '0;
  assign ack_mask  = (int_rst && intr) ? (CHANNELS'(1) << vec) : '0;
  assign stat_clr  = (wr_hit && off6 == 6'(OFF_STAT)) ? bus_in[CHANNELS-1:0] : '0;
  assign pend_next = (pending & ~(ack_mask | stat_clr)) | set_mask;

`ifdef RTC_ALARM_PERIODIC_EN
  logic [CNT_SIZE-1:0] reload [CHANNELS];
`endif

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cmp[k]   <= '0;
        ch_en[k] <= 1'b0;
      end else begin
        if (wr_hit && off6 == 6'(OFF_CMP0 + 2 * k)) cmp[k] <= bus_in;
`ifdef RTC_ALARM_PERIODIC_EN
        else if (scan_hit && int'(idx) == k && reload[k] != '0) cmp[k] <= cmp[k] + reload[k];
`endif
        if (wr_hit && off6 == 6'(OFF_CMP0 + 2 * k + 1)) ch_en[k] <= bus_in[CHCTL_EN_BIT];
      end
    end
`ifdef RTC_ALARM_PERIODIC_EN
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) reload[k] <= '0;
      else if (wr_hit && off6 == 6'(NREG_BASE + k)) reload[k] <= bus_in;
    end
`endif
  end

  always_comb begin
    bus_out = '0;
    if (rd && hit) begin
      if (off6 == 6'(OFF_CTRL))  bus_out[CTRL_EN_BIT] = en;
      if (off6 == 6'(OFF_PRESC)) bus_out = CNT_SIZE'(presc_reg);
      if (off6 == 6'(OFF_CNT))   bus_out = cnt;
      if (off6 == 6'(OFF_STAT)) begin
        bus_out[CHANNELS-1:0] = pending;
        bus_out[STAT_OVR_BIT] = ovr;
      end
      for (int k = 0; k < CHANNELS; k++) begin
        if (off6 == 6'(OFF_CMP0 + 2 * k))     bus_out = cmp[k];
        if (off6 == 6'(OFF_CMP0 + 2 * k + 1)) bus_out = CNT_SIZE'(ch_en[k]);
`ifdef RTC_ALARM_PERIODIC_EN
        if (off6 == 6'(NREG_BASE + k))        bus_out = reload[k];
`endif
      end
    end
  end

  rtc_rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .pending (pend_next),
    .ack     (int_rst),
    .vec     (vec),
    .intr    (intr),
    .ptr     (rr_ptr)
  );

endmodule

// File: tb/tb_rtc_alarm_sched.sv
// tb/tb_rtc_alarm_sched.sv - scoreboard bench for rtc_alarm_sched: directed register/alarm scenarios
module tb_rtc_alarm_sched;

  localparam int K_INTR = 0, K_VEC = 1, K_STATE = 2, K_BUS = 3, K_LEFT = 4;
  localparam int A_CTRL = 0, A_PRESC = 1, A_CNT = 2, A_STAT = 3;

  typedef struct {
    int kind;
    int exp;
  } lvl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  addr = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [15:0] bus_in = '0;
  logic [15:0] bus_out;
  logic        intr;
  logic [1:0]  vec;
  logic        int_rst = 1'b0;

  int   exp_rd[$];
  int   exp_vec[$];
  lvl_t lvl_q[$];
  int   errors = 0;
  int   checks = 0;
  lvl_t l;
  int   e, act;

  rtc_alarm_sched dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .bus_in(bus_in),
    .bus_out(bus_out), .intr(intr), .vec(vec), .int_rst(int_rst)
  );

  always #5 clk = ~clk;

  // monitor: all comparisons happen here, half a cycle after inputs settle
  always @(negedge clk) begin
    while (lvl_q.size() > 0) begin
      l = lvl_q.pop_front();
      case (l.kind)
        K_INTR:  act = int'(intr);
        K_VEC:   act = int'(vec);
        K_STATE: act = int'(dut.state);
        K_BUS:   act = int'(bus_out);
        default: act = exp_vec.size();
      endcase
      checks++;
      if (act != l.exp) begin
        errors++;
        $display("FAIL level kind=%0d t=%0t actual=%0d required=%0d", l.kind, $time, act, l.exp);
      end
    end
    if (rd) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected addr=%0d actual=%0h", addr, bus_out);
      end else begin
        e = exp_rd.pop_front();
        if (int'(bus_out) != e) begin
          errors++;
          $display("FAIL read addr=%0d t=%0t actual=%0h required=%0h", addr, $time, bus_out, e);
        end
      end
    end
    if (int_rst && intr) begin
      checks++;
      if (exp_vec.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected actual_vec=%0d", vec);
      end else begin
        e = exp_vec.pop_front();
        if (int'(vec) != e) begin
          errors++;
          $display("FAIL ack_vec t=%0t actual=%0d required=%0d", $time, vec, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_lvl(input int kind, input int exp);
    lvl_q.push_back('{kind, exp});
  endtask

  task automatic wreg(input int a, input int d);
    addr = 6'(a); bus_in = 16'(d); wr = 1'b1;
    step(1);
    wr = 1'b0;
  endtask

  task automatic rreg(input int a, input int exp);
    exp_rd.push_back(exp);
    addr = 6'(a); rd = 1'b1;
    step(1);
    rd = 1'b0;
  endtask

  task automatic wait_intr(input int bound);
    int n;
    n = 0;
    while (!intr && n < bound) begin
      step(1);
      n++;
    end
    if (!intr) expect_lvl(K_INTR, 1);
  endtask

  task automatic ack(input int v);
    wait_intr(100);
    exp_vec.push_back(v);
    int_rst = 1'b1;
    step(1);
    int_rst = 1'b0;
  endtask

  initial begin
    step(2);
    expect_lvl(K_INTR, 0);
    expect_lvl(K_VEC, 0);
    rst = 1'b1;
    step(1);
    expect_lvl(K_BUS, 0);
    rreg(A_CTRL, 0);
    rreg(A_CNT, 0);
    rreg(A_STAT, 0);
    rreg(A_PRESC, 0);

    // three channels match the same count; presented in index order
    wreg(A_PRESC, 3);
    wreg(4, 7); wreg(6, 100); wreg(8, 7); wreg(10, 7);
    for (int k = 0; k < 4; k++) wreg(5 + 2 * k, 1);
    rreg(4, 7);
    wreg(A_CTRL, 3);
    ack(0); ack(2); ack(3);
    expect_lvl(K_INTR, 0);
    wreg(A_CNT, 6);
    ack(0); ack(2); ack(3);
    expect_lvl(K_INTR, 0);

    // basic match timing: CNT=5 at tick 5, intr two cycles after that tick
    wreg(A_CTRL, 0);
    wreg(4, 5); wreg(7, 0); wreg(9, 0); wreg(11, 0);
    step(8);
    wreg(A_CTRL, 3);
    step(20);
    expect_lvl(K_INTR, 0);
    step(1);
    expect_lvl(K_INTR, 1);
    expect_lvl(K_VEC, 0);
    rreg(A_CNT, 5);
    ack(0);
    expect_lvl(K_INTR, 0);

    // collision: scan sets pending1 in the cycle it is acknowledged
    wreg(A_CTRL, 0);
    wreg(5, 0); wreg(6, 1); wreg(7, 1);
    step(8);
    wreg(A_CTRL, 3);
    wait_intr(40);
    expect_lvl(K_VEC, 1);
    wreg(A_CTRL, 0);
    step(8);
    wreg(A_CTRL, 3);
    step(5);
    exp_vec.push_back(1);
    int_rst = 1'b1;
    step(1);
    int_rst = 1'b0;
    expect_lvl(K_INTR, 1);
    step(1);
    expect_lvl(K_INTR, 1);
    expect_lvl(K_VEC, 1);
    rreg(A_STAT, 16'h0002);
    ack(1);
    expect_lvl(K_INTR, 0);

    // overrun: tick every cycle against a 4-cycle scan
    wreg(A_CTRL, 0);
    wreg(7, 0);
    step(6);
    wreg(A_PRESC, 0);
    wreg(A_CTRL, 3);
    step(5);
    rreg(A_STAT, 16'h8000);
    wreg(A_CTRL, 0);
    step(6);
    rreg(A_STAT, 16'h8000);
    wreg(A_STAT, 16'h8000);
    rreg(A_STAT, 0);

`ifdef RTC_ALARM_PERIODIC_EN
    wreg(A_PRESC, 3);
    wreg(6, 10); wreg(13, 10); wreg(7, 1);
    wreg(A_CTRL, 3);
    ack(1); ack(1); ack(1);
    rreg(6, 40);
    wreg(A_CTRL, 0);
    wreg(13, 0); wreg(6, 10);
    wreg(A_CTRL, 3);
    ack(1);
    step(100);
    rreg(A_STAT, 0);
    rreg(6, 10);
    wreg(A_CTRL, 0);
    wreg(7, 0);
`else
    wreg(13, 16'h1234);
    rreg(13, 0);
`endif

    // reset mid-scan with pending0 set, pointer left at 2 by earlier acks
    wreg(A_PRESC, 3);
    wreg(4, 3); wreg(8, 3); wreg(5, 1); wreg(9, 1);
    step(8);
    wreg(A_CTRL, 3);
    step(14);
    expect_lvl(K_INTR, 1);
    expect_lvl(K_VEC, 0);
    expect_lvl(K_STATE, 1);
    step(1);
    expect_lvl(K_VEC, 2);
    step(1);
    rst = 1'b0;
    #1;
    exp_rd.push_back(0);
    addr = 6'(A_CNT); rd = 1'b1;
    expect_lvl(K_INTR, 0);
    expect_lvl(K_VEC, 0);
    step(1);
    rd = 1'b0;
    rst = 1'b1;
    step(1);
    expect_lvl(K_STATE, 0);
    expect_lvl(K_INTR, 0);
    rreg(A_STAT, 0);
    rreg(A_CTRL, 0);

    expect_lvl(K_LEFT, 0);
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
